// File: rtl/serial_sub_pkg.sv
// Purpose: shared FSM encoding and counter sizing for the bit-serial subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width: ceil(log2(width)), never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_sub.sv
// Purpose: 1-bit full subtractor, s = a - b - cIn, cOut = borrow-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operand bits; cIn borrow-in; s difference bit; cOut borrow-out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic cIn,
    output logic s,
    output logic cOut
);

    assign s    = a ^ b ^ cIn;
    // Borrow when b exceeds a, or when a == b and a borrow is already pending.
    assign cOut = (~a & b) | (~(a ^ b) & cIn);

endmodule

// File: rtl/serial_sub.sv
// Purpose: bit-serial WIDTH-bit subtractor (a - b - bin) around one full_sub cell.
// Latency: done pulses WIDTH+1 cycles after the accepted start; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy/done are dropped, no queuing.
// Ports: clk, rst_n (sync, active-low); start/a/b/bin request; busy, done pulse, diff, bout result.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             fs_s;
    logic             fs_cout;

    full_sub u_full_sub (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cIn  (borrow),
        .s    (fs_s),
        .cOut (fs_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are pure state decodes, so busy and done can never overlap.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand shifters, borrow flop, bit counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        diff   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow <= fs_cout;
                    cnt    <= cnt + 1'b1;
                    // Difference bits enter at the MSB; after WIDTH shifts bit i sits in diff[i].
                    diff   <= {fs_s, diff[WIDTH-1:1]};
                    // bout stays at the previous result until the last bit is processed.
                    if (cnt == LAST_BIT) begin
                        bout <= fs_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
